// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request/response structs,
// FSM state encoding and interface widths.
package dmem_responder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = WORD_W / 8;
    localparam int unsigned WAIT_W = 4;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic              we;
        logic [STRB_W-1:0] wstrb;
        logic [WORD_W-1:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              err;
    } dmem_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM, one access per cycle, per-byte write
// enables.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter string       INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [STRB_W-1:0]        i_we,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [WORD_W-1:0]        i_wdata,
    output logic [WORD_W-1:0]        o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_q;

    // Read returns the pre-write word; the responder masks read data on writes.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_we[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            r_q <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/dmem_responder.sv
// Target side of the core's data-memory port: accepts a request, accesses the
// RAM, and returns read data or a range fault after WAIT_CYCLES wait states.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [32:0] LIMIT   = 33'(DEPTH) << 2;
    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

    dmem_state_t       r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_rsp_valid;
    logic              r_we;
    logic              r_cap;
    dmem_rsp_t         r_rsp;

    dmem_req_t         w_req;
    logic [31:0]       w_off;
    logic              w_in_range;
    logic [AW-1:0]     w_idx;
    logic              w_accept;
    logic [STRB_W-1:0] w_ram_we;
    logic [31:0]       w_ram_q;
    logic [31:0]       w_rd;

    assign w_req = '{addr: req_addr, we: req_we, wstrb: req_wstrb, wdata: req_wdata};

    // Offset wraps high for addresses below BASE_ADDR, so one compare covers both ends.
    assign w_off      = w_req.addr - BASE_ADDR;
    assign w_in_range = {1'b0, w_off} < LIMIT;
    assign w_idx      = w_off[AW+1:2];

    assign req_ready = !rst && ((r_state == IDLE) || (r_state == RESP && rsp_ready));
    assign w_accept  = req_valid && req_ready;
    assign w_ram_we  = (w_accept && w_req.we && w_in_range) ? w_req.wstrb : '0;

    dmem_array #(
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk    (clk),
        .i_en   (w_accept),
        .i_we   (w_ram_we),
        .i_idx  (w_idx),
        .i_wdata(w_req.wdata),
        .o_rdata(w_ram_q)
    );

    assign w_rd = (r_we || r_rsp.err) ? '0 : w_ram_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_we        <= 1'b0;
            r_cap       <= 1'b0;
            r_rsp       <= '0;
        end else begin
            // RAM output is copied into the response register one cycle after issue.
            r_cap <= w_accept;
            if (r_cap) r_rsp.rdata <= w_rd;

            if (w_accept) begin
                r_we       <= w_req.we;
                r_rsp.err  <= !w_in_range;
                r_wait_cnt <= WAIT_LD;
                if (WAIT_CYCLES > 0) begin
                    r_state     <= WAIT;
                    r_rsp_valid <= 1'b0;
                end else begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                end
            end else begin
                case (r_state)
                    WAIT: begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                        if (r_wait_cnt == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                    RESP: begin
                        if (rsp_ready) begin
                            r_state     <= IDLE;
                            r_rsp_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_cap ? w_rd : r_rsp.rdata;
    assign rsp_err   = r_rsp.err;

endmodule
